// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port synchronous-read data memory between the core (port 0)
//   and the host/debug port (port 1). A registered grant FSM (IDLE/OWN0/OWN1)
//   picks the owner. Arbitration is round-robin on ties, and each owner is capped
//   at MAX_BURST consecutive beats while the other port is waiting. Read data
//   comes back one cycle after the read beat, with a one-cycle rvalid strobe.
//
//   Optional build macro DMEM_ARB_CORE_PRIO_EN: port 0 gets absolute priority.
//   It wins ties, preempts an OWN1 burst, and is never burst-limited.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req/we/addr/wdata 0,1    requests; held stable until the beat is taken
//   gnt0, gnt1               registered grants; a beat occurs when reqN & gntN
//   rvalid0/1, rdata0/1      read response, one cycle after the read beat
//   mem_e/we/addr/di         memory control, combinational, zero when no beat
//   mem_do                   memory read data, valid the cycle after a read beat
//   busy                     FSM not idle
module dmem_arbiter #(
  parameter int AW        = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_e,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_di,
  input  logic [DW-1:0] mem_do,
  output logic          busy
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t        state;
  logic          rr_ptr;
  logic [CW-1:0] beat_cnt;
  logic          beat0, beat1;
  logic          tie0;           // port 0 wins a tie from IDLE
  logic          yield0, yield1; // owner must hand over if the other port waits
  logic [DW-1:0] hold0, hold1;

  assign beat0 = gnt0 & req0;
  assign beat1 = gnt1 & req1;
  assign busy  = (state != IDLE);

`ifdef DMEM_ARB_CORE_PRIO_EN
  assign tie0   = 1'b1;
  assign yield0 = 1'b0;
  assign yield1 = 1'b1;
`else
  assign tie0   = (rr_ptr == 1'b0);
  assign yield0 = (beat_cnt == LAST);
  assign yield1 = (beat_cnt == LAST);
`endif

  // Grant FSM. The gnt registers are always equal to (state==OWNx).
  // beat_cnt saturates at LAST, so an uncontested burst runs on indefinitely.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rr_ptr   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (req0 && (!req1 || tie0)) begin
            state <= OWN0;
            gnt0  <= 1'b1;
          end else if (req1) begin
            state <= OWN1;
            gnt1  <= 1'b1;
          end
        end
        OWN0: begin
          if (!req0) begin
            rr_ptr   <= 1'b1;
            beat_cnt <= '0;
            gnt0     <= 1'b0;
            if (req1) begin
              state <= OWN1;
              gnt1  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (req1 && yield0) begin
            state    <= OWN1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b1;
            rr_ptr   <= 1'b0;
            beat_cnt <= '0;
          end else if (beat_cnt != LAST) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        OWN1: begin
          if (!req1) begin
            rr_ptr   <= 1'b0;
            beat_cnt <= '0;
            gnt1     <= 1'b0;
            if (req0) begin
              state <= OWN0;
              gnt0  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (req0 && yield1) begin
            state    <= OWN0;
            gnt1     <= 1'b0;
            gnt0     <= 1'b1;
            rr_ptr   <= 1'b1;
            beat_cnt <= '0;
          end else if (beat_cnt != LAST) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          gnt0     <= 1'b0;
          gnt1     <= 1'b0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // Memory muxes. The grants are one-hot, so at most one beat is live.
  always_comb begin
    mem_e    = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_di   = '0;
    if (beat0) begin
      mem_e    = 1'b1;
      mem_we   = we0;
      mem_addr = addr0;
      mem_di   = wdata0;
    end else if (beat1) begin
      mem_e    = 1'b1;
      mem_we   = we1;
      mem_addr = addr1;
      mem_di   = wdata1;
    end
  end

  // Read return. This path is independent of the FSM, so a read in the last
  // beat of an ownership still strobes while the new owner starts its beats.
  // rdata shows mem_do during the strobe and holds the last value afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      hold0   <= '0;
      hold1   <= '0;
    end else begin
      rvalid0 <= beat0 & ~we0;
      rvalid1 <= beat1 & ~we1;
      if (rvalid0) hold0 <= mem_do;
      if (rvalid1) hold1 <= mem_do;
    end
  end

  assign rdata0 = rvalid0 ? mem_do : hold0;
  assign rdata1 = rvalid1 ? mem_do : hold1;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       mem_e, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_di;
  logic [7:0] mem_do = 8'h00;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  dmem_arbiter #(.AW(4), .DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_e(mem_e), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
    .mem_do(mem_do), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: 16 x 8, sync read. Preloaded with {a, ~a}, so addr 3 = 0x3C.
  logic [7:0] mem [16];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= {4'(i), ~4'(i)};
      loaded <= 1'b1;
    end else if (mem_e === 1'b1) begin
      if (mem_we) mem[mem_addr] <= mem_di;
      else        mem_do <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Response monitor: every rvalid must match the oldest expected read for that port.
  always @(negedge clk) begin
    if (rvalid0 === 1'b1) begin
      if (q0.size() == 0) chk("unexpected_rvalid0", 32'(rvalid0), 32'd0);
      else chk("rdata0", 32'(rdata0), 32'(q0.pop_front()));
    end
    if (rvalid1 === 1'b1) begin
      if (q1.size() == 0) chk("unexpected_rvalid1", 32'(rvalid1), 32'd0);
      else chk("rdata1", 32'(rdata1), 32'(q1.pop_front()));
    end
    if (loaded && rst === 1'b0) chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 4'd0; addr1 = 4'd0; wdata0 = 8'h00; wdata1 = 8'h00;

    // Reset with both requests held high.
    nxt(); nxt();
    smp();
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_rvalid0", 32'(rvalid0), 0);
    chk("rst_rvalid1", 32'(rvalid1), 0);
    chk("rst_mem_e", 32'(mem_e), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdata0", 32'(rdata0), 0);
    chk("rst_rdata1", 32'(rdata1), 0);
    nxt();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;

    // Port 1: write 0xA5 to addr 5, then read it back.
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd5; wdata1 = 8'hA5;
    smp(); chk("t2_no_gnt_yet", 32'(gnt1), 0);
    nxt();
    smp();
    chk("t2_gnt1", 32'(gnt1), 1);
    chk("t2_mem_e", 32'(mem_e), 1);
    chk("t2_mem_we", 32'(mem_we), 1);
    chk("t2_mem_addr", 32'(mem_addr), 5);
    chk("t2_mem_di", 32'(mem_di), 32'hA5);
    nxt();
    we1 = 1'b0;
    smp();
    chk("t2_rd_mem_we", 32'(mem_we), 0);
    q1.push_back(8'hA5);
    nxt();
    req1 = 1'b0;
    smp(); chk("t2_no_beat_req_low", 32'(mem_e), 0);
    nxt();
    smp(); chk("t2_idle", 32'(busy), 0);
    nxt();

    // Contention from a fresh reset; port 0 reads addr 3, port 1 reads addr 5.
    rst = 1'b1; nxt(); rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd5;
    for (int k = 0; k <= 12; k++) begin
      smp();
`ifdef DMEM_ARB_CORE_PRIO_EN
      e = (k == 0) ? -1 : 0;
`else
      e = (k == 0) ? -1 : (((k - 1) / 4) % 2);
`endif
      chk($sformatf("t3_gnt0_c%0d", k), 32'(gnt0), 32'(e == 0));
      chk($sformatf("t3_gnt1_c%0d", k), 32'(gnt1), 32'(e == 1));
      if (e == 0) q0.push_back(8'h3C);
      if (e == 1) q1.push_back(8'hA5);
`ifndef DMEM_ARB_CORE_PRIO_EN
      if (k == 5) begin
        chk("t5_boundary_rvalid0", 32'(rvalid0), 1);
        chk("t5_boundary_rdata0", 32'(rdata0), 32'h3C);
        chk("t5_boundary_mem_addr", 32'(mem_addr), 5);
      end
`endif
      nxt();
    end
    req0 = 1'b0; req1 = 1'b0;
    smp(); chk("t3_drop_no_beat", 32'(mem_e), 0);
    nxt();
    smp(); chk("t3_idle", 32'(busy), 0);
    nxt();

    // Release handoff, then tie-break direction after each release.
    req0 = 1'b1; addr0 = 4'd3;
    smp(); chk("t4_lat", 32'(gnt0), 0);
    nxt();
    smp(); chk("t4_gnt0", 32'(gnt0), 1); q0.push_back(8'h3C);
    nxt();
    req1 = 1'b1; addr1 = 4'd5;
    smp(); chk("t4_gnt0_keep", 32'(gnt0), 1); q0.push_back(8'h3C);
    nxt();
    req0 = 1'b0;
    smp();
    chk("t4_release_no_beat", 32'(mem_e), 0);
    chk("t4_release_busy", 32'(busy), 1);
    nxt();
    smp();
    chk("t4_handoff_gnt1", 32'(gnt1), 1);
    chk("t4_handoff_busy", 32'(busy), 1);
    chk("t4_handoff_addr", 32'(mem_addr), 5);
    q1.push_back(8'hA5);
    nxt();
    req1 = 1'b0;
    smp(); nxt();
    req0 = 1'b1; req1 = 1'b1;
    smp(); chk("t4_tie_idle", 32'(busy), 0);
    nxt();
    smp(); chk("t4_tie_favours0", 32'(gnt0), 1); q0.push_back(8'h3C);
    nxt();
    req0 = 1'b0; req1 = 1'b0;
    smp(); nxt();
    req0 = 1'b1; req1 = 1'b1;
    smp(); nxt();
    smp();
`ifdef DMEM_ARB_CORE_PRIO_EN
    chk("t4_tie2_gnt0", 32'(gnt0), 1); q0.push_back(8'h3C);
`else
    chk("t4_tie2_favours1", 32'(gnt1), 1); q1.push_back(8'hA5);
`endif
    nxt();
    req0 = 1'b0; req1 = 1'b0;
    smp(); nxt();
    smp(); chk("t4_end_idle", 32'(busy), 0);
    nxt();

    // Reset in the middle of a port 1 read burst.
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd5;
    smp(); nxt();
    smp(); chk("t6_gnt1", 32'(gnt1), 1); q1.push_back(8'hA5);
    nxt();
    smp(); q1.push_back(8'hA5);
    nxt();
    rst = 1'b1;
    smp(); nxt();
    rst = 1'b0; req1 = 1'b0;
    smp();
    chk("t6_gnt1_dropped", 32'(gnt1), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_rvalid1_suppressed", 32'(rvalid1), 0);
    chk("t6_q1_drained", 32'(q1.size()), 0);
    nxt();
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd5;
    smp(); nxt();
    smp(); chk("t6_readback_gnt0", 32'(gnt0), 1); q0.push_back(8'hA5);
    nxt();
    addr0 = 4'd3;
    smp(); q0.push_back(8'h3C);
    nxt();
    req0 = 1'b0;
    smp(); nxt();

`ifdef DMEM_ARB_CORE_PRIO_EN
    // Port 0 preempts a port 1 burst after one beat.
    req1 = 1'b1; addr1 = 4'd5;
    smp(); nxt();
    req0 = 1'b1; addr0 = 4'd3;
    smp(); chk("t6p_gnt1", 32'(gnt1), 1); q1.push_back(8'hA5);
    nxt();
    smp();
    chk("t6p_gnt0", 32'(gnt0), 1);
    chk("t6p_gnt1_off", 32'(gnt1), 0);
    q0.push_back(8'h3C);
    nxt();
    req0 = 1'b0; req1 = 1'b0;
    smp(); nxt();
`endif

    smp(); nxt();
    smp();
    chk("final_q0_empty", 32'(q0.size()), 0);
    chk("final_q1_empty", 32'(q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
